// File: rtl/daq_arb_pkg.sv
// Shared definitions for the DAQ DMA arbiter: FSM encoding, header layout and
// the helper that assembles the 64-bit routing header.
package daq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [7:0] HDR_MAGIC_DEFAULT = 8'hDA;

  localparam int MAGIC_LSB = 56;
  localparam int FPGA_LSB  = 48;
  localparam int SRC_LSB   = 40;
  localparam int CNT_LSB   = 0;

  localparam int MAX_SRC = 8;

  // Unused header bits stay zero so downstream parsers can rely on them.
  function automatic logic [63:0] make_header(input logic [7:0]  magic,
                                              input logic [7:0]  fpga,
                                              input logic [2:0]  src,
                                              input logic [31:0] cnt);
    logic [63:0] h;
    h = '0;
    h[MAGIC_LSB +: 8] = magic;
    h[FPGA_LSB  +: 8] = fpga;
    h[SRC_LSB   +: 3] = src;
    h[CNT_LSB   +: 32] = cnt;
    return h;
  endfunction

endpackage

// File: rtl/daq_dma_arbiter_rr_picker.sv
// Combinational round-robin picker: rotates the request vector so the search
// starts just above the previous winner, then priority-encodes the lowest bit.
module rr_picker
  import daq_arb_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] req,
  input  logic [2:0]       last_grant,
  output logic [2:0]       pick,
  output logic             any
);

  localparam int IW = $clog2(2 * N_SRC);

  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  logic [IW-1:0]      start_w;
  int                 start;
  int                 offset;

  // Doubling the vector lets a plain part-select act as a rotate with wrap.
  always_comb begin
    start   = (int'(last_grant) + 1) % N_SRC;
    start_w = IW'(start);
    dbl     = {req, req};
    rot     = dbl[start_w +: N_SRC];
    offset  = 0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) offset = i;
    end
    pick = 3'((start + offset) % N_SRC);
    any  = |req;
  end

endmodule

// File: rtl/daq_dma_arbiter.sv
// Packet-granular round-robin arbiter merging N_SRC DAQ streams onto one DMA
// stream, prefixing each packet with a routing header.
module daq_dma_arbiter
  import daq_arb_pkg::*;
#(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_SRC-1:0]      enable_mask,
  input  logic [7:0]            fpga_id,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [64*N_SRC-1:0]   src_data,
  input  logic [N_SRC-1:0]      src_last,
  output logic [N_SRC-1:0]      src_ready,
  output logic                  dma_valid,
  output logic [63:0]           dma_data,
  output logic                  dma_last,
  input  logic                  dma_ready,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic [31:0]           pkt_count
);

  state_t      state, next_state;
  logic [2:0]  last_grant, grant_q, pick;
  logic        any;
  logic [N_SRC-1:0] req;
  logic [31:0] pkt_cnt_q;
  logic        busy_q;
  logic        sel_valid, sel_last;
  logic [63:0] sel_data;
  logic        pkt_done;

  assign req = src_valid & enable_mask;

  rr_picker #(.N_SRC(N_SRC)) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .any        (any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == 3'(i)) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[64*i +: 64];
      end
    end
  end

  assign pkt_done = (state == STREAM) && sel_valid && dma_ready && sel_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any) next_state = HEADER;
      HEADER:  if (dma_ready) next_state = STREAM;
      STREAM:  if (pkt_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The grant is only sampled in IDLE, so mask changes cannot preempt a packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 3'(N_SRC - 1);
      grant_q    <= '0;
      pkt_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= (next_state != IDLE);
      if (state == IDLE && any) grant_q <= pick;
      if (pkt_done) begin
        last_grant <= grant_q;
        pkt_cnt_q  <= pkt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    dma_valid = 1'b0;
    dma_last  = 1'b0;
    dma_data  = '0;
    src_ready = '0;
    case (state)
      HEADER: begin
        dma_valid = 1'b1;
        dma_data  = make_header(HDR_MAGIC, fpga_id, grant_q, pkt_cnt_q);
      end
      STREAM: begin
        dma_valid = sel_valid;
        dma_data  = sel_data;
        dma_last  = sel_last;
        for (int i = 0; i < N_SRC; i++) begin
          if (grant_q == 3'(i)) src_ready[i] = dma_ready;
        end
      end
      default: ;
    endcase
  end

  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_daq_dma_arbiter.sv
// Bench for daq_dma_arbiter: per-source packet queues feed the DUT and every
// DMA word is checked against an expected-word scoreboard.
module tb_daq_dma_arbiter;

  localparam int N_SRC = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [N_SRC-1:0]    enable_mask;
  logic [7:0]          fpga_id;
  logic [N_SRC-1:0]    src_valid = '0;
  logic [64*N_SRC-1:0] src_data  = '0;
  logic [N_SRC-1:0]    src_last  = '0;
  logic [N_SRC-1:0]    src_ready;
  logic                dma_valid;
  logic [63:0]         dma_data;
  logic                dma_last;
  logic                dma_ready;
  logic [2:0]          grant_id;
  logic                busy;
  logic [31:0]         pkt_count;

  daq_dma_arbiter #(.N_SRC(N_SRC), .HDR_MAGIC(8'hDA)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable_mask (enable_mask),
    .fpga_id     (fpga_id),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .dma_valid   (dma_valid),
    .dma_data    (dma_data),
    .dma_last    (dma_last),
    .dma_ready   (dma_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] req;
    int         exp_grant;
  } row_t;

  row_t        rows [10];
  logic [64:0] src_q [N_SRC][$];
  logic [64:0] exp_q [$];
  logic [N_SRC-1:0] hs;
  logic [31:0] cnt_model;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          rx_count = 0;

  task automatic check_output(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [2:0] src, input logic [31:0] cnt);
    return {8'hDA, fpga_id, 5'h0, src, 8'h0, cnt};
  endfunction

  function automatic logic [63:0] wordv(input int tag, input int k);
    return 64'hC0DE_0000_0000_0000 | (64'(tag) << 16) | 64'(k);
  endfunction

  // Source model: handshakes sampled mid-cycle, queues advanced just after the edge.
  always @(negedge clk) hs = src_valid & src_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N_SRC; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        src_valid[i]         = 1'b1;
        src_data[64*i +: 64] = src_q[i][0][63:0];
        src_last[i]          = src_q[i][0][64];
      end else begin
        src_valid[i]         = 1'b0;
        src_data[64*i +: 64] = '0;
        src_last[i]          = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && dma_valid && dma_ready) begin
      rx_count++;
      if (exp_q.size() == 0) check_output("unexpected_word", {dma_last, dma_data}, 65'h0);
      else check_output("dma_word", {dma_last, dma_data}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic load_src(input int src, input int n, input int tag);
    for (int k = 0; k < n; k++)
      src_q[src].push_back({(k == n - 1) ? 1'b1 : 1'b0, wordv(tag, k)});
  endtask

  task automatic expect_pkt(input int src, input int n, input int tag);
    exp_q.push_back({1'b0, hdr(3'(src), cnt_model)});
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == n - 1) ? 1'b1 : 1'b0, wordv(tag, k)});
    cnt_model++;
  endtask

  task automatic wait_busy(input string name);
    int t;
    t = 0;
    sample();
    while (!busy && t < 100) begin
      sample();
      t++;
    end
    check_output(name, 65'(busy), 65'd1);
  endtask

  task automatic wait_rx(input string name, input int target);
    int t;
    t = 0;
    sample();
    while (rx_count < target && t < 100) begin
      sample();
      t++;
    end
    check_output(name, 65'(rx_count), 65'(target));
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    sample();
    while ((busy || exp_q.size() != 0) && t < 200) begin
      sample();
      t++;
    end
    check_output(name, 65'(exp_q.size()), 65'd0);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N_SRC; i++) src_q[i].delete();
  endtask

  task automatic apply_reset();
    tick();
    reset_n = 1'b0;
    exp_q.delete();
    clear_queues();
    cnt_model = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic apply_stimulus(input int r);
    tick();
    enable_mask = rows[r].mask;
    fpga_id     = 8'h10 + 8'(r);
    for (int i = 0; i < N_SRC; i++)
      if (rows[r].req[i]) load_src(i, 1, 16 + r);
    expect_pkt(rows[r].exp_grant, 1, 16 + r);
    wait_busy($sformatf("row%0d_busy", r));
    check_output($sformatf("row%0d_grant", r), 65'(grant_id), 65'(rows[r].exp_grant));
    tick();
    enable_mask = '0;
    wait_drain($sformatf("row%0d_drain", r));
    tick();
    clear_queues();
    tick();
    tick();
  endtask

  initial begin
    logic [63:0] h;
    int rx0;

    rows[0] = '{4'hF, 4'b0100, 2};
    rows[1] = '{4'hF, 4'b1011, 3};
    rows[2] = '{4'hF, 4'b0011, 0};
    rows[3] = '{4'hE, 4'b0011, 1};
    rows[4] = '{4'hF, 4'b0011, 0};
    rows[5] = '{4'h5, 4'b1111, 2};
    rows[6] = '{4'hF, 4'b0001, 0};
    rows[7] = '{4'hF, 4'b0001, 0};
    rows[8] = '{4'h8, 4'b1001, 3};
    rows[9] = '{4'hF, 4'b1000, 3};

    reset_n     = 1'b1;
    dma_ready   = 1'b1;
    enable_mask = '1;
    fpga_id     = 8'h5A;
    cnt_model   = '0;
    #3 reset_n = 1'b0;
    #1;
    check_output("rst_dma_valid", 65'(dma_valid), 65'd0);
    check_output("rst_dma_last",  65'(dma_last),  65'd0);
    check_output("rst_dma_data",  65'(dma_data),  65'd0);
    check_output("rst_src_ready", 65'(src_ready), 65'd0);
    check_output("rst_busy",      65'(busy),      65'd0);
    check_output("rst_grant_id",  65'(grant_id),  65'd0);
    check_output("rst_pkt_count", 65'(pkt_count), 65'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Single 3-word packet from source 2.
    tick();
    load_src(2, 3, 1);
    expect_pkt(2, 3, 1);
    wait_drain("seqA_drain");
    check_output("seqA_pkt_count", 65'(pkt_count), 65'd1);
    check_output("seqA_grant_id",  65'(grant_id),  65'd2);

    apply_reset();
    for (int r = 0; r < 10; r++) apply_stimulus(r);
    enable_mask = '1;

    // All sources requesting continuously: strict rotation with no preemption.
    apply_reset();
    tick();
    load_src(0, 2, 40); load_src(1, 2, 41); load_src(2, 2, 42);
    load_src(3, 2, 43); load_src(0, 2, 44); load_src(1, 2, 45);
    expect_pkt(0, 2, 40); expect_pkt(1, 2, 41); expect_pkt(2, 2, 42);
    expect_pkt(3, 2, 43); expect_pkt(0, 2, 44); expect_pkt(1, 2, 45);
    wait_drain("seqB_drain");
    check_output("seqB_pkt_count", 65'(pkt_count), 65'd6);
    check_output("seqB_grant_id",  65'(grant_id),  65'd1);

    // Mask drops the active source mid-packet; the packet must still finish.
    apply_reset();
    tick();
    load_src(1, 4, 50);
    expect_pkt(1, 4, 50);
    rx0 = rx_count;
    wait_rx("seqC_rx", rx0 + 2);
    tick();
    enable_mask = 4'b1101;
    load_src(0, 1, 51);
    load_src(1, 1, 52);
    expect_pkt(0, 1, 51);
    wait_drain("seqC_drain");
    check_output("seqC_grant_id", 65'(grant_id), 65'd0);
    tick();
    src_q[1].delete();
    tick();
    tick();
    enable_mask = '1;

    // Back-pressure during the header and during the second data word.
    tick();
    dma_ready = 1'b0;
    h = hdr(3'd3, cnt_model);
    load_src(3, 3, 60);
    expect_pkt(3, 3, 60);
    rx0 = rx_count;
    wait_busy("seqD_busy");
    for (int j = 0; j < 5; j++) begin
      check_output("seqD_hdr_stall_data", 65'(dma_data), 65'(h));
      check_output("seqD_hdr_stall_ready", 65'(src_ready), 65'd0);
      sample();
    end
    tick();
    dma_ready = 1'b1;
    wait_rx("seqD_rx", rx0 + 2);
    tick();
    dma_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      sample();
      check_output("seqD_word_stall_data", {dma_valid, dma_data}, {1'b1, wordv(60, 1)});
      check_output("seqD_word_stall_ready", 65'(src_ready), 65'd0);
    end
    tick();
    dma_ready = 1'b1;
    wait_drain("seqD_drain");

    // Asynchronous reset in the middle of a packet.
    tick();
    load_src(0, 1, 70);
    expect_pkt(0, 1, 70);
    wait_drain("seqE_pre_drain");
    tick();
    load_src(1, 4, 71);
    expect_pkt(1, 4, 71);
    rx0 = rx_count;
    wait_rx("seqE_rx", rx0 + 2);
    tick();
    reset_n = 1'b0;
    #1;
    check_output("seqE_dma_valid", 65'(dma_valid), 65'd0);
    check_output("seqE_src_ready", 65'(src_ready), 65'd0);
    check_output("seqE_busy",      65'(busy),      65'd0);
    check_output("seqE_pkt_count", 65'(pkt_count), 65'd0);
    exp_q.delete();
    clear_queues();
    cnt_model = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    load_src(0, 1, 72);
    load_src(1, 1, 73);
    expect_pkt(0, 1, 72);
    expect_pkt(1, 1, 73);
    wait_drain("seqE_post_drain");
    check_output("seqE_grant_id", 65'(grant_id), 65'd1);

    // Counter wrap via backdoor preload.
    tick();
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.pkt_cnt_q;
    cnt_model = 32'hFFFF_FFFF;
    load_src(2, 1, 80);
    expect_pkt(2, 1, 80);
    wait_drain("seqF_drain");
    check_output("seqF_pkt_count", 65'(pkt_count), 65'd0);
    check_output("seqF_grant_id",  65'(grant_id),  65'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
